// File: rtl/microsequencer.sv
// Microinstruction sequencer: steps T through the fixed fetch words and the
// {opcode, T}-addressed microcode ROM, with run/halt, single-step and a retired count.
module microsequencer #(
    parameter int OPC_BITS  = 8,
    parameter int STEP_BITS = 3,
    parameter int CNT_BITS  = 16
) (
    input  logic                          clk,
    input  logic                          reset_bar,
    input  logic [OPC_BITS-1:0]           opcode,
    input  logic [15:0]                   rom_data,
    input  logic                          RT,
    input  logic                          run,
    input  logic                          step_req,
    output logic [OPC_BITS+STEP_BITS-1:0] rom_addr,
    output logic [15:0]                   uinstr,
    output logic [STEP_BITS-1:0]          T,
    output logic                          halted,
    output logic                          step_ack,
    output logic [CNT_BITS-1:0]           icount
);

    localparam logic [15:0]          FETCH0   = 16'h8120;
    localparam logic [15:0]          FETCH1   = 16'hB540;
    localparam logic [15:0]          NOP      = 16'hC100;
    localparam logic [STEP_BITS-1:0] T_ZERO   = '0;
    localparam logic [STEP_BITS-1:0] T_ONE    = {{(STEP_BITS-1){1'b0}}, 1'b1};
    localparam logic [STEP_BITS-1:0] T_MAX    = '1;
    localparam logic [CNT_BITS-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_HALT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [STEP_BITS-1:0]  r_t;
    logic                  r_step_ack;
    logic                  r_step_armed;
    logic                  r_seen_low;
    logic [CNT_BITS-1:0]   r_icount;
    logic                  w_retire;
    logic [15:0]           w_uinstr;

    assign T        = r_t;
    assign halted   = (r_state == S_HALT);
    assign step_ack = r_step_ack;
    assign icount   = r_icount;
    assign rom_addr = {opcode, r_t};
    assign uinstr   = w_uinstr;

    // RT is only honoured past the fetch words, which never assert it.
    assign w_retire = (r_t == T_MAX) || (RT && (r_t > T_ONE));

    // Microinstruction select: parked NOP, fixed fetch pair, then ROM.
    always_comb begin
        w_uinstr = NOP;
        if (r_state == S_HALT) begin
            w_uinstr = NOP;
        end else if (r_t == T_ZERO) begin
            w_uinstr = FETCH0;
        end else if (r_t == T_ONE) begin
            w_uinstr = FETCH1;
        end else begin
            w_uinstr = rom_data;
        end
    end

    // Sequencer state: microstep, run/halt, single-step handshake and retire count.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_state      <= S_HALT;
            r_t          <= T_ZERO;
            r_step_ack   <= 1'b0;
            r_step_armed <= 1'b0;
            r_seen_low   <= 1'b1;
            r_icount     <= CNT_ZERO;
        end else begin
            r_step_ack <= 1'b0;
            if (!step_req) begin
                r_seen_low <= 1'b1;
            end
            case (r_state)
                S_HALT: begin
                    if (run) begin
                        r_state <= S_RUN;
                    end else if (step_req && !r_step_armed && r_seen_low) begin
                        r_state      <= S_RUN;
                        r_step_armed <= 1'b1;
                        r_seen_low   <= 1'b0;
                    end else begin
                        r_state <= S_HALT;
                    end
                end
                S_RUN: begin
                    if (w_retire) begin
                        r_t      <= T_ZERO;
                        r_icount <= r_icount + CNT_ONE;
                        if (r_step_armed) begin
                            r_step_ack   <= 1'b1;
                            r_step_armed <= 1'b0;
                            r_state      <= S_HALT;
                        end else if (!run) begin
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_t <= r_t + T_ONE;
                    end
                end
                default: begin
                    r_state <= S_HALT;
                    r_t     <= T_ZERO;
                end
            endcase
        end
    end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Generates the 16-bit microinstruction word that the control decoder turns into control signals.
- Holds the microstep counter T and forces the two fixed fetch microinstructions.
- Addresses the asynchronous microcode ROM with {opcode, T} for execute steps and honours RT (return to fetch) from the decoder.
- Provides run/halt and single-step control, and a retired-instruction counter for debug.

Parameters:
- OPC_BITS, 8, opcode width (IR high byte).
- STEP_BITS, 3, microstep counter width; 2**STEP_BITS steps per opcode.
- CNT_BITS, 16, retired-instruction counter width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_bar  input  1  asynchronous, active-low reset.
- opcode  input  OPC_BITS  IR[15:8], the current instruction's opcode.
- rom_data  input  16  microcode ROM read data; combinational from rom_addr.
- RT  input  1  decoded return-to-fetch from the control decoder.
- run  input  1  1 = free-run; 0 = halt at the next instruction boundary.
- step_req  input  1  level request for one instruction while halted.
- rom_addr  output  OPC_BITS+STEP_BITS  {opcode, T}.
- uinstr  output  16  current microinstruction to the control decoder.
- T  output  STEP_BITS  current microstep.
- halted  output  1  sequencer parked at T=0 and emitting NOP.
- step_ack  output  1  one-cycle pulse when a single-stepped instruction retires.
- icount  output  CNT_BITS  instructions retired since reset, wrapping.

Behaviour:
- Reset (asynchronous, active-low): T=0, halted=1, step_ack=0, icount=0, step_armed=0. Reset asserted mid-instruction aborts it immediately; no retirement is counted.
- Constants:
  - FETCH0 = 0x8120 (PC out, MAR in).
  - FETCH1 = 0xB540 (RAM out, IR in, P+).
  - NOP = 0xC100 (EO_bar=1, bus_out=4 spare, bus_in=0, no jumps).
- uinstr, combinational:
  - halted=1 → NOP.
  - T=0 → FETCH0.
  - T=1 → FETCH1.
  - otherwise → rom_data.
- rom_addr = {opcode, T} at all times, including while halted (the ROM has no side effects).
- T update, only when halted=0:
  - T==2**STEP_BITS-1, or (RT=1 and T≥2) → T=0 (retire).
  - Otherwise T=T+1.
  - RT is ignored when T<2, because fetch words never assert it.
- Retire event:
  - icount increments by 1 and wraps from all-ones to 0.
  - If run=0 and no step is armed, halted becomes 1 in the same edge.
  - If step_armed=1, step_ack=1 for exactly the next cycle, step_armed clears, and halted becomes 1.
- Leaving halt, evaluated only while halted=1 (T is 0):
  - run=1 → halted=0 next edge.
  - Else step_req=1 and step_armed=0 → halted=0 and step_armed=1 next edge.
- step_req is level-sensitive. Each further step needs step_req to be low for at least one cycle between requests; a separate "seen low" flag enforces this.
- run dropping mid-instruction: the instruction completes and the halt happens at retire. run rising mid single-step: the pending step_ack is still produced, and the sequencer then continues free-running.
- step_ack is 0 in every cycle other than the single pulse.

Test Plan:
- Reset then run=1, opcode=0x12, ROM returns 0x0000 with RT=0: uinstr sequence 0x8120, 0xB540, then rom_addr 0x092..0x097 for T=2..7; T wraps to 0; icount=1 after 8 cycles.
- RT=1 asserted at T=3: next T=0 and uinstr=0x8120; icount increments; instruction length is 4 cycles.
- RT=1 held at T=0 and T=1: no early retire; T advances 0→1→2.
- Halted with run=0, step_req pulsed high for 3 cycles: exactly one instruction executes, step_ack is high for one cycle, halted=1, uinstr=0xC100; no second instruction until step_req goes low then high.
- run dropped at T=4: T continues to retire, then halted=1 with T=0 and uinstr=0xC100.
- reset_bar low asynchronously at T=5: T=0, halted=1, icount=0 without a clock edge; icount wrap from 0xFFFF to 0x0000 on retire.
